// File: rtl/router_output_arbiter.sv
// rtl/router_output_arbiter.sv - packet-atomic round-robin arbiter sharing one router output FIFO
// A grant is held from the first flit to the tail flit so packets never interleave.
module router_output_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int PORT_IDX_WIDTH = 2,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            src_empty_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] src_d_out,
    input  logic [NUM_PORTS-1:0]            src_tail,
    output logic [NUM_PORTS-1:0]            src_deq,
    input  logic                            dst_full_n,
    output logic                            dst_enq,
    output logic [DATA_WIDTH-1:0]           dst_d_in,
    output logic                            grant_valid,
    output logic [PORT_IDX_WIDTH-1:0]       grant_idx,
    output logic [CNT_WIDTH-1:0]            pkt_count
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [PORT_IDX_WIDTH-1:0] r_grant_idx;
    logic [PORT_IDX_WIDTH-1:0] r_last_grant;
    logic [CNT_WIDTH-1:0]      r_pkt_count;

    logic [PORT_IDX_WIDTH-1:0] w_pick;
    logic [PORT_IDX_WIDTH:0]   w_sum;
    logic [PORT_IDX_WIDTH-1:0] w_cand;
    logic                      w_any_req;
    logic                      w_xfer;
    logic                      w_tail_xfer;
    logic [DATA_WIDTH-1:0]     w_granted_flit;

    // Scan downward from last_grant+NUM_PORTS so the last hit is the first requester above last_grant.
    always_comb begin
        w_pick    = '0;
        w_any_req = 1'b0;
        w_sum     = '0;
        w_cand    = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_sum = {1'b0, r_last_grant} + (PORT_IDX_WIDTH+1)'(k);
            if (w_sum >= (PORT_IDX_WIDTH+1)'(NUM_PORTS)) begin
                w_sum = w_sum - (PORT_IDX_WIDTH+1)'(NUM_PORTS);
            end
            w_cand = w_sum[PORT_IDX_WIDTH-1:0];
            if (src_empty_n[w_cand]) begin
                w_pick    = w_cand;
                w_any_req = 1'b1;
            end
        end
    end

    always_comb begin
        w_granted_flit = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (r_grant_idx == PORT_IDX_WIDTH'(k)) begin
                w_granted_flit = src_d_out[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_xfer      = (r_state == ST_BUSY) & src_empty_n[r_grant_idx] & dst_full_n & ~reset;
    assign w_tail_xfer = w_xfer & src_tail[r_grant_idx];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_req)   w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_tail_xfer) w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant_idx  <= '0;
            r_last_grant <= PORT_IDX_WIDTH'(NUM_PORTS - 1);
            r_pkt_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_grant_idx <= w_pick;
            end
            if (w_tail_xfer) begin
                r_last_grant <= r_grant_idx;
                r_pkt_count  <= r_pkt_count + CNT_WIDTH'(1);
            end
        end
    end

    assign src_deq     = w_xfer ? (NUM_PORTS'(1) << r_grant_idx) : '0;
    assign dst_enq     = w_xfer;
    assign dst_d_in    = reset ? '0 : w_granted_flit;
    assign grant_valid = (r_state == ST_BUSY);
    assign grant_idx   = r_grant_idx;
    assign pkt_count   = r_pkt_count;

endmodule

// File: tb/tb_router_output_arbiter.sv
// tb/tb_router_output_arbiter.sv - scoreboard bench for router_output_arbiter
module tb_router_output_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;

    typedef struct packed {
        logic [1:0]    port;
        logic [DW-1:0] data;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [NP-1:0]     src_empty_n;
    logic [NP*DW-1:0]  src_d_out;
    logic [NP-1:0]     src_tail;
    logic [NP-1:0]     src_deq;
    logic              dst_full_n;
    logic              dst_enq;
    logic [DW-1:0]     dst_d_in;
    logic              grant_valid;
    logic [1:0]        grant_idx;
    logic [15:0]       pkt_count;

    logic [DW:0]       q_src [NP][$];
    exp_t              exp_q [$];
    logic [NP-1:0]     mask;
    logic [NP-1:0]     deq_seen;
    int                vectors;
    int                miscompares;

    router_output_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .PORT_IDX_WIDTH(2), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset),
        .src_empty_n(src_empty_n), .src_d_out(src_d_out), .src_tail(src_tail),
        .src_deq(src_deq), .dst_full_n(dst_full_n), .dst_enq(dst_enq),
        .dst_d_in(dst_d_in), .grant_valid(grant_valid), .grant_idx(grant_idx),
        .pkt_count(pkt_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            if (q_src[i].size() > 0) begin
                src_empty_n[i]          = !mask[i];
                src_tail[i]             = q_src[i][0][DW];
                src_d_out[i*DW +: DW]   = q_src[i][0][DW-1:0];
            end else begin
                src_empty_n[i]          = 1'b0;
                src_tail[i]             = 1'b0;
                src_d_out[i*DW +: DW]   = '0;
            end
        end
    endtask

    // Source FIFOs pop after the edge on which the monitor saw their deq strobe.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (deq_seen[i] && q_src[i].size() > 0) void'(q_src[i].pop_front());
        end
        drive();
    endtask

    task automatic push_src(input int port, input logic [DW-1:0] data, input logic tail);
        q_src[port].push_back({tail, data});
    endtask

    task automatic push_exp(input int port, input logic [DW-1:0] data);
        exp_t e;
        e.port = 2'(port);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic push_pkt(input int port, input logic [DW-1:0] base, input int len);
        for (int k = 0; k < len; k++) begin
            push_src(port, base + DW'(k), (k == len - 1));
            push_exp(port, base + DW'(k));
        end
    endtask

    function automatic bit srcs_empty();
        for (int i = 0; i < NP; i++) if (q_src[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_done(input string name);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            tick();
            n++;
            done = (exp_q.size() == 0) && !grant_valid && srcs_empty();
        end
        check({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        for (int i = 0; i < NP; i++) q_src[i].delete();
        mask       = '0;
        dst_full_n = 1'b1;
        reset      = 1'b1;
        drive();
        tick();
        tick();
        check("rst_grant_valid", 32'(grant_valid), 32'd0);
        check("rst_grant_idx", 32'(grant_idx), 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        reset = 1'b0;
        tick();
    endtask

    always @(negedge clk) begin
        exp_t e;
        vectors++;
        if (((src_deq & (src_deq - NP'(1))) != '0) || (dst_enq != (|src_deq)) ||
            ((src_deq & ~src_empty_n) != '0) || (dst_enq && !dst_full_n)) begin
            miscompares++;
            $display("FAIL invariant: src_deq=%b dst_enq=%b src_empty_n=%b dst_full_n=%b required legal strobes",
                     src_deq, dst_enq, src_empty_n, dst_full_n);
        end
        if (reset) begin
            vectors++;
            if (src_deq != '0 || dst_enq || dst_d_in != '0) begin
                miscompares++;
                $display("FAIL reset_outputs: src_deq=%b dst_enq=%b dst_d_in=%0h required all 0",
                         src_deq, dst_enq, dst_d_in);
            end
        end
        if (dst_enq) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_flit: got %0h from src_deq=%b required no transfer", dst_d_in, src_deq);
            end else begin
                e = exp_q.pop_front();
                if (dst_d_in !== e.data || src_deq !== (NP'(1) << e.port)) begin
                    miscompares++;
                    $display("FAIL flit: got %0h src_deq=%b expected %0h src_deq=%b",
                             dst_d_in, src_deq, e.data, NP'(1) << e.port);
                end
            end
        end
        deq_seen = src_deq;
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        deq_seen    = '0;
        mask        = '0;
        src_empty_n = '0;
        src_tail    = '0;
        src_d_out   = '0;
        dst_full_n  = 1'b1;

        do_reset();

        // single 3-flit packet from port 2
        push_pkt(2, 32'hA0, 3);
        drive();
        tick();
        check("t1_grant_valid", 32'(grant_valid), 32'd1);
        check("t1_grant_idx", 32'(grant_idx), 32'd2);
        wait_done("t1");
        check("t1_pkt_count", 32'(pkt_count), 32'd1);

        // all ports contend with 2-flit packets: 0,1,2,3,0
        do_reset();
        push_pkt(0, 32'hB00, 2);
        push_pkt(1, 32'hB10, 2);
        push_pkt(2, 32'hB20, 2);
        push_pkt(3, 32'hB30, 2);
        push_pkt(0, 32'hB08, 2);
        drive();
        wait_done("t2");
        check("t2_pkt_count", 32'(pkt_count), 32'd5);

        // destination back-pressure for 3 cycles on port 1
        push_pkt(1, 32'hC0, 4);
        drive();
        tick();
        check("t3_grant_idx", 32'(grant_idx), 32'd1);
        tick();
        dst_full_n = 1'b0;
        drive();
        for (int s = 0; s < 3; s++) begin
            tick();
            check("t3_stall_grant", 32'({grant_valid, grant_idx}), 32'h5);
        end
        dst_full_n = 1'b1;
        drive();
        wait_done("t3");
        check("t3_pkt_count", 32'(pkt_count), 32'd6);

        // port 0 source runs dry mid-packet while port 3 waits
        push_pkt(0, 32'hD0, 3);
        drive();
        tick();
        check("t4_grant_idx", 32'(grant_idx), 32'd0);
        push_pkt(3, 32'hE0, 2);
        drive();
        tick();
        mask[0] = 1'b1;
        drive();
        for (int s = 0; s < 2; s++) begin
            tick();
            check("t4_hold_grant", 32'({grant_valid, grant_idx}), 32'h4);
        end
        mask[0] = 1'b0;
        drive();
        wait_done("t4");
        check("t4_pkt_count", 32'(pkt_count), 32'd8);

        // single-flit packets with the idle bubble between them
        push_pkt(0, 32'hF0, 1);
        push_pkt(3, 32'hF3, 1);
        drive();
        tick();
        check("t5_first_grant", 32'({grant_valid, grant_idx}), 32'h4);
        tick();
        check("t5_bubble", 32'(grant_valid), 32'd0);
        tick();
        check("t5_second_grant", 32'({grant_valid, grant_idx}), 32'h7);
        wait_done("t5");
        push_pkt(0, 32'hF8, 1);
        push_pkt(2, 32'hFA, 1);
        drive();
        wait_done("t5b");
        check("t5_pkt_count", 32'(pkt_count), 32'd12);

        // reset in the middle of a port-2 packet
        push_src(2, 32'h90, 1'b0);
        push_src(2, 32'h91, 1'b0);
        push_src(2, 32'h92, 1'b0);
        push_src(2, 32'h93, 1'b1);
        push_exp(2, 32'h90);
        drive();
        tick();
        check("t6_grant_idx", 32'(grant_idx), 32'd2);
        tick();
        reset = 1'b1;
        tick();
        check("t6_grant_valid", 32'(grant_valid), 32'd0);
        check("t6_pkt_count", 32'(pkt_count), 32'd0);
        check("t6_grant_idx_rst", 32'(grant_idx), 32'd0);
        q_src[2].delete();
        push_pkt(1, 32'h71, 1);
        push_pkt(3, 32'h73, 1);
        reset = 1'b0;
        drive();
        tick();
        check("t6_post_rst_grant", 32'({grant_valid, grant_idx}), 32'h5);
        wait_done("t6");
        check("t6_pkt_count_end", 32'(pkt_count), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/router_output_arbiter.md
Name: router_output_arbiter

Overview:
- Round-robin arbiter that shares one router output FIFO among NUM_PORTS source FIFOs.
- Source and destination sides use the FIFO enq/deq/full_n/empty_n handshake the router FIFOs expose.
- Grants are packet-atomic: a grant is held until the source's tail flit has been transferred, so packets never interleave on the output.
- Sits between the per-input routerFIFOs and the output-port routerFIFO.

Parameters:
- NUM_PORTS, 4, number of requesting source FIFOs (2..8).
- DATA_WIDTH, 32, flit width in bits.
- PORT_IDX_WIDTH, 2, width of the grant index; must equal clog2(NUM_PORTS).
- CNT_WIDTH, 16, width of the completed-packet counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- src_empty_n  input  NUM_PORTS  bit i high = source i head flit valid.
- src_d_out  input  NUM_PORTS*DATA_WIDTH  source head flits; port i at [i*DATA_WIDTH +: DATA_WIDTH].
- src_tail  input  NUM_PORTS  bit i high = source i head flit is the last flit of its packet.
- src_deq  output  NUM_PORTS  one-hot pop strobe to the granted source.
- dst_full_n  input  1  destination FIFO can accept a flit this cycle.
- dst_enq  output  1  push strobe to the destination FIFO.
- dst_d_in  output  DATA_WIDTH  flit to the destination FIFO.
- grant_valid  output  1  high while a packet grant is held (BUSY).
- grant_idx  output  PORT_IDX_WIDTH  index of the granted source; valid when grant_valid is high.
- pkt_count  output  CNT_WIDTH  number of completed packets; wraps modulo 2^CNT_WIDTH.

Behaviour:
- States: IDLE and BUSY.
- Reset (synchronous, takes priority over everything):
  - State goes to IDLE; grant_valid=0; grant_idx=0; pkt_count=0.
  - last_grant=NUM_PORTS-1, so port 0 has top priority after reset.
  - src_deq, dst_enq and dst_d_in are all 0 during reset.
- IDLE:
  - If any src_empty_n bit is set, select the first set bit scanning upward from last_grant+1 (mod NUM_PORTS).
  - Register it as grant_idx, set grant_valid=1, go to BUSY next cycle.
  - No transfer occurs in IDLE.
  - If no bit is set, stay in IDLE.
- BUSY, transfer condition: xfer = src_empty_n[grant_idx] & dst_full_n.
  - While xfer is high, in the same cycle (combinational): src_deq[grant_idx]=1, dst_enq=1, dst_d_in = flit of port grant_idx.
  - Otherwise src_deq=0, dst_enq=0, and dst_d_in holds the granted port's flit (don't-care for the destination).
- BUSY, tail transfer: when xfer and src_tail[grant_idx] are both high:
  - Next cycle: IDLE, grant_valid=0, last_grant=grant_idx, pkt_count+1.
- Timing:
  - Arbitration latency is 1 cycle (request seen in IDLE, first flit moves the following cycle).
  - One idle bubble follows each packet.
  - Maximum throughput is L/(L+1) flits per cycle for L-flit packets.
- Stalls in BUSY:
  - Granted source empties mid-packet: hold the grant and wait; no enq/deq.
  - Destination full: hold; no deq. Never assert dst_enq while dst_full_n=0.
  - Never assert src_deq[i] while src_empty_n[i]=0.
- Single-flit packet (tail on the first flit): transfer one flit, then return to IDLE.
- Non-granted sources:
  - Their src_empty_n and src_tail are ignored in BUSY.
  - Their src_deq bits stay 0.
- Fairness: the granted port gets lowest priority in the next arbitration. Worst-case wait is NUM_PORTS-1 packets.
- pkt_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.
- Reset mid-packet: the grant is dropped and state goes to IDLE. The partial packet in the destination is not the arbiter's concern.
- Invariant: src_deq is one-hot or zero every cycle; dst_enq == |src_deq.

Test Plan:
- Reset then only port 2 requests a 3-flit packet (0xA0, 0xA1, 0xA2 with tail) and dst_full_n=1 -> grant_idx=2 one cycle after the request; flits appear on consecutive cycles; pkt_count=1; back to IDLE.
- All 4 ports request 2-flit packets continuously -> grant order 0,1,2,3,0; no interleaving; pkt_count increments by 1 per packet.
- Port 1 is granted and dst_full_n drops for 3 cycles mid-packet -> dst_enq=0 and src_deq=0 for those 3 cycles; flit order is preserved; grant_idx stays 1.
- Port 0 is granted and src_empty_n[0] drops for 2 cycles mid-packet while port 3 requests -> grant held on port 0; port 3 served only after port 0's tail.
- Single-flit packets from ports 0 and 3 -> each is transferred in 1 cycle with a 1-cycle bubble between; last_grant updates to 0, then 3.
- Reset asserted during BUSY on port 2 -> next cycle grant_valid=0, pkt_count=0, all strobes 0; first grant after reset goes to the lowest requesting port.
